// File: rtl/mtl_timing_pkg.sv
// Shared timing constants, bus payload types and colour-bar table for the
// MTL 800x480 raster generator.
package mtl_timing_pkg;

  localparam int unsigned XW = 11;
  localparam int unsigned YW = 10;
  localparam int unsigned CW = 8;

  localparam int unsigned DEF_H_ACTIVE = 800;
  localparam int unsigned DEF_H_FP     = 210;
  localparam int unsigned DEF_H_SW     = 1;
  localparam int unsigned DEF_H_BP     = 45;
  localparam int unsigned DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SW + DEF_H_BP;

  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 22;
  localparam int unsigned DEF_V_SW     = 1;
  localparam int unsigned DEF_V_BP     = 22;
  localparam int unsigned DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SW + DEF_V_BP;

  localparam int unsigned BAR_W = 100;

  typedef struct packed {
    logic [CW-1:0] r;
    logic [CW-1:0] g;
    logic [CW-1:0] b;
  } rgb_t;

  typedef struct packed {
    logic vis;
    logic hs_n;
    logic vs_n;
  } sync_bus_t;

  // Blanked, syncs idle (active-low syncs high)
  localparam sync_bus_t SYNC_IDLE = 3'b011;

  // Eight vertical colour bars, white through black
  function automatic rgb_t bar_color(input logic [2:0] idx);
    rgb_t c;
    c = '0;
    case (idx)
      3'd0: c = 24'hFF_FF_FF;
      3'd1: c = 24'hFF_FF_00;
      3'd2: c = 24'h00_FF_FF;
      3'd3: c = 24'h00_FF_00;
      3'd4: c = 24'hFF_00_FF;
      3'd5: c = 24'hFF_00_00;
      3'd6: c = 24'h00_00_FF;
      default: c = 24'h00_00_00;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mtl_sync_delay.sv
// Enable-gated shift register carrying {vis, hs_n, vs_n} across the
// renderer latency.
module mtl_sync_delay
  import mtl_timing_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      en,
  input  sync_bus_t d,
  output sync_bus_t q
);

  sync_bus_t stage [DEPTH];

  // Shift one stage per enabled clock; reset fills with idle sync
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= SYNC_IDLE;
    end else if (en) begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/mtl_raster_gen.sv
// Raster timing generator and pixel output stage for the MTL 800x480 panel.
// Issues x/y scan coordinates, delays sync/DE by the renderer latency and
// registers colour, sync and DE together.
// Optional: define MTL_TEST_PATTERN_EN to replace renderer colour with
// eight vertical colour bars.
module mtl_raster_gen
  import mtl_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SW     = DEF_H_SW,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SW     = DEF_V_SW,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter int unsigned PIPE_LAT = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic [CW-1:0] red,
  input  logic [CW-1:0] green,
  input  logic [CW-1:0] blue,
  output logic [XW-1:0] x_cnt,
  output logic [YW-1:0] y_cnt,
  output logic          frame_start,
  output logic          lcd_hsd,
  output logic          lcd_vsd,
  output logic          lcd_de,
  output logic [CW-1:0] lcd_r,
  output logic [CW-1:0] lcd_g,
  output logic [CW-1:0] lcd_b
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SW + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SW + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SW;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SW;

  // Reject unsupported renderer latencies at elaboration
  if (PIPE_LAT == 0 || PIPE_LAT > 8) begin : g_bad_pipe_lat
    $fatal(1, "mtl_raster_gen: PIPE_LAT must be within 1..8");
  end

  logic          x_wrap_c;
  logic          y_wrap_c;
  logic [XW-1:0] x_nxt_c;
  logic [YW-1:0] y_nxt_c;
  sync_bus_t     sync_c;
  sync_bus_t     sync_d;
  rgb_t          pix_c;

  // Next scan coordinate: x wraps each line, y advances on x wrap
  always_comb begin
    x_wrap_c = (x_cnt == XW'(H_TOTAL - 1));
    y_wrap_c = (y_cnt == YW'(V_TOTAL - 1));
    x_nxt_c  = x_wrap_c ? '0 : x_cnt + XW'(1);
    y_nxt_c  = y_cnt;
    if (x_wrap_c) y_nxt_c = y_wrap_c ? '0 : y_cnt + YW'(1);
  end

  // Scan counters and frame-start flag, aligned to the issued coordinate
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_cnt       <= '0;
      y_cnt       <= '0;
      frame_start <= 1'b0;
    end else if (en) begin
      x_cnt       <= x_nxt_c;
      y_cnt       <= y_nxt_c;
      frame_start <= (x_nxt_c == '0) && (y_nxt_c == '0);
    end
  end

  // Issue-side visibility and active-low syncs decoded from the counters
  always_comb begin
    sync_c      = SYNC_IDLE;
    sync_c.vis  = (x_cnt < XW'(H_ACTIVE)) && (y_cnt < YW'(V_ACTIVE));
    sync_c.hs_n = !((x_cnt >= XW'(HS_START)) && (x_cnt < XW'(HS_END)));
    sync_c.vs_n = !((y_cnt >= YW'(VS_START)) && (y_cnt < YW'(VS_END)));
  end

  mtl_sync_delay #(
    .DEPTH (PIPE_LAT)
  ) u_sync_delay (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .d     (sync_c),
    .q     (sync_d)
  );

`ifdef MTL_TEST_PATTERN_EN
  logic [XW-1:0] x_dly [PIPE_LAT];

  // x coordinate follows the sync bus so bars line up with DE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < PIPE_LAT; i++) x_dly[i] <= '0;
    end else if (en) begin
      x_dly[0] <= x_cnt;
      for (int i = 1; i < PIPE_LAT; i++) x_dly[i] <= x_dly[i-1];
    end
  end

  // Colour bar chosen by delayed x in 100-pixel bands
  always_comb begin
    pix_c = bar_color(3'(x_dly[PIPE_LAT-1][9:0] / 10'(BAR_W)));
  end
`else
  // Renderer colour passes straight to the output register
  always_comb begin
    pix_c.r = red;
    pix_c.g = green;
    pix_c.b = blue;
  end
`endif

  // Panel output register; colour blanked outside the visible area
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lcd_de  <= 1'b0;
      lcd_hsd <= 1'b1;
      lcd_vsd <= 1'b1;
      lcd_r   <= '0;
      lcd_g   <= '0;
      lcd_b   <= '0;
    end else if (en) begin
      lcd_de  <= sync_d.vis;
      lcd_hsd <= sync_d.hs_n;
      lcd_vsd <= sync_d.vs_n;
      lcd_r   <= sync_d.vis ? pix_c.r : '0;
      lcd_g   <= sync_d.vis ? pix_c.g : '0;
      lcd_b   <= sync_d.vis ? pix_c.b : '0;
    end
  end

endmodule

// File: tb/tb_mtl_raster_gen.sv
// Directed bench for mtl_raster_gen. Horizontal timing is the panel default;
// the vertical total is shortened to 11 lines so whole frames fit a short run.
module tb_mtl_raster_gen;

  localparam int unsigned V_ACT  = 6;
  localparam int unsigned V_FPT  = 2;
  localparam int unsigned V_SWT  = 1;
  localparam int unsigned V_BPT  = 2;
  localparam int unsigned LINE   = 1056;
  localparam int unsigned FRAME  = LINE * 11;

`ifdef MTL_TEST_PATTERN_EN
  localparam logic [23:0] EXP0   = 24'hFFFFFF;
  localparam logic [23:0] EXP100 = 24'hFFFF00;
  localparam logic [23:0] EXP700 = 24'h000000;
`else
  localparam logic [23:0] EXP0   = 24'h56A998;
  localparam logic [23:0] EXP100 = 24'h56A998;
  localparam logic [23:0] EXP700 = 24'h56A998;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [7:0]  red, green, blue;
  logic [10:0] x_cnt;
  logic [9:0]  y_cnt;
  logic        frame_start, lcd_hsd, lcd_vsd, lcd_de;
  logic [7:0]  lcd_r, lcd_g, lcd_b;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n;
  int held;
  logic [48:0] snap;

  always #5 clk = ~clk;

  mtl_raster_gen #(
    .V_ACTIVE (V_ACT),
    .V_FP     (V_FPT),
    .V_SW     (V_SWT),
    .V_BP     (V_BPT),
    .PIPE_LAT (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .red         (red),
    .green       (green),
    .blue        (blue),
    .x_cnt       (x_cnt),
    .y_cnt       (y_cnt),
    .frame_start (frame_start),
    .lcd_hsd     (lcd_hsd),
    .lcd_vsd     (lcd_vsd),
    .lcd_de      (lcd_de),
    .lcd_r       (lcd_r),
    .lcd_g       (lcd_g),
    .lcd_b       (lcd_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; cyc counts enabled edges since the last reset release
  task automatic tick();
    @(posedge clk);
    #1;
    if (en) cyc++;
  endtask

  function automatic logic [48:0] outs();
    return {x_cnt, y_cnt, lcd_de, lcd_hsd, lcd_vsd, frame_start, lcd_r, lcd_g, lcd_b};
  endfunction

  initial begin
    reset = 1'b1;
    en    = 1'b0;
    red   = 8'h56;
    green = 8'hA9;
    blue  = 8'h98;
    repeat (3) @(posedge clk);
    #1;
    check("rst_x",   32'(x_cnt), 32'd0);
    check("rst_y",   32'(y_cnt), 32'd0);
    check("rst_de",  32'(lcd_de), 32'd0);
    check("rst_hsd", 32'(lcd_hsd), 32'd1);
    check("rst_vsd", 32'(lcd_vsd), 32'd1);
    check("rst_rgb", 32'({lcd_r, lcd_g, lcd_b}), 32'd0);
    check("rst_fs",  32'(frame_start), 32'd0);

    // Release: first DE exactly three clocks after the (0,0) coordinate
    reset = 1'b0;
    en    = 1'b1;
    cyc   = 0;
    tick();
    tick();
    check("lat_de_early", 32'(lcd_de), 32'd0);
    tick();
    check("lat_de", 32'(lcd_de), 32'd1);
    check("lat_rgb", 32'({lcd_r, lcd_g, lcd_b}), 32'(EXP0));
    check("lat_x", 32'(x_cnt), 32'd3);

    // Line 0: count DE-high clocks and sample bar boundaries
    n = 1;
    while (lcd_de && cyc < 2000) begin
      tick();
      if (cyc == 102) check("pix99",  32'({lcd_r, lcd_g, lcd_b}), 32'(EXP0));
      if (cyc == 103) check("pix100", 32'({lcd_r, lcd_g, lcd_b}), 32'(EXP100));
      if (cyc == 703) check("pix700", 32'({lcd_r, lcd_g, lcd_b}), 32'(EXP700));
      if (lcd_de) n++;
    end
    check("line0_de_count", 32'(n), 32'd800);
    check("line0_de_fall", 32'(cyc), 32'd803);
    check("blank_rgb", 32'({lcd_r, lcd_g, lcd_b}), 32'd0);

    // Horizontal sync: one clock, 1010 clocks after first DE of the line
    while (lcd_hsd && cyc < 2000) tick();
    check("hsd_start", 32'(cyc), 32'd1013);
    check("hsd_x", 32'(x_cnt), 32'd1013);
    tick();
    check("hsd_width", 32'(lcd_hsd), 32'd1);

    // Line period
    while (!lcd_de && cyc < 3000) tick();
    check("line1_de_rise", 32'(cyc), 32'(LINE + 3));
    check("line1_y", 32'(y_cnt), 32'd1);

    // Freeze mid-line for 37 clocks; line must still carry 800 DE clocks
    n = 1;
    while (cyc < 1200) begin
      tick();
      n += int'(lcd_de);
    end
    snap = outs();
    en   = 1'b0;
    held = 1;
    repeat (37) begin
      tick();
      if (outs() !== snap) held = 0;
    end
    check("en_hold", 32'(held), 32'd1);
    check("en_hold_x", 32'(x_cnt), 32'd144);
    en = 1'b1;
    while (lcd_de && cyc < 4000) begin
      tick();
      n += int'(lcd_de);
    end
    check("line1_de_count", 32'(n), 32'd800);

    // Vertical sync: one whole line, 8 lines after the first DE line
    while (lcd_vsd && cyc < 10000) tick();
    check("vsd_start", 32'(cyc), 32'(8 * LINE + 3));
    check("vsd_y", 32'(y_cnt), 32'd8);
    n = 0;
    while (!lcd_vsd && cyc < 12000) begin
      n++;
      tick();
    end
    check("vsd_width", 32'(n), 32'(LINE));

    // Frame start on the (1055, last line) -> (0,0) wrap
    while (!frame_start && cyc < 13000) tick();
    check("fs_first", 32'(cyc), 32'(FRAME));
    check("fs_coord", 32'({x_cnt, y_cnt}), 32'd0);
    tick();
    check("fs_pulse_width", 32'(frame_start), 32'd0);
    while (!frame_start && cyc < 24000) tick();
    check("fs_period", 32'(cyc), 32'(2 * FRAME));

    // Asynchronous reset mid-frame at (400, 3)
    while (cyc < 2 * FRAME + 3 * LINE + 400) tick();
    check("pre_rst_x", 32'(x_cnt), 32'd400);
    check("pre_rst_y", 32'(y_cnt), 32'd3);
    check("pre_rst_de", 32'(lcd_de), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("arst_x",   32'(x_cnt), 32'd0);
    check("arst_y",   32'(y_cnt), 32'd0);
    check("arst_de",  32'(lcd_de), 32'd0);
    check("arst_hsd", 32'(lcd_hsd), 32'd1);
    check("arst_vsd", 32'(lcd_vsd), 32'd1);
    check("arst_rgb", 32'({lcd_r, lcd_g, lcd_b}), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc   = 0;
    tick();
    check("restart_x", 32'(x_cnt), 32'd1);
    check("restart_y", 32'(y_cnt), 32'd0);
    tick();
    tick();
    check("restart_de", 32'(lcd_de), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mtl_raster_gen.md
# mtl_raster_gen

Raster timing generator and pixel output stage for the MTL 800x480 LCD panel. Drives the `x_cnt`/`y_cnt` scan coordinates consumed by the pixel renderers, such as the cube renderer. Takes the renderers' registered `red`/`green`/`blue` back and re-aligns panel sync and data-enable to that renderer latency, so colour, sync and DE leave the block on the same cycle.

## Interface
- `H_ACTIVE`, 800, visible pixels per line
- `H_FP`, 210, horizontal front porch (clocks)
- `H_SW`, 1, hsync width (clocks)
- `H_BP`, 45, horizontal back porch; H_TOTAL = 1056
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP`, 22, vertical front porch (lines)
- `V_SW`, 1, vsync width (lines)
- `V_BP`, 22, vertical back porch; V_TOTAL = 525
- `PIPE_LAT`, 2, renderer latency in clocks from `x_cnt`/`y_cnt` to `red`/`green`/`blue`; legal range 1..8
- `clk`  in  1  pixel clock
- `reset`  in  1  asynchronous, active-high reset
- `en`  in  1  scan enable; counters and delay line hold while low
- `red`, `green`, `blue`  in  8 each  renderer colour for the coordinate issued PIPE_LAT cycles earlier
- `x_cnt`  out  11  horizontal position, 0..H_TOTAL-1; values below H_ACTIVE are visible
- `y_cnt`  out  10  vertical position, 0..V_TOTAL-1; values below V_ACTIVE are visible
- `frame_start`  out  1  one-cycle pulse while the issued coordinate is (0,0)
- `lcd_hsd`, `lcd_vsd`  out  1 each  panel syncs, active low
- `lcd_de`  out  1  panel data enable
- `lcd_r`, `lcd_g`, `lcd_b`  out  8 each  panel colour

## Operation
- Line order: active region, then front porch, then sync, then back porch. The x counter increments every enabled cycle and wraps H_TOTAL-1 -> 0. The y counter increments on each x wrap and wraps V_TOTAL-1 -> 0.
- Issue-side signals, combinational from the counters:
  - vis = (x_cnt < H_ACTIVE) && (y_cnt < V_ACTIVE)
  - hs_n is low for x_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SW)
  - vs_n is low for y_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SW), over whole lines
- Delay line: {vis, hs_n, vs_n} pass through a PIPE_LAT-stage shift register that advances only when `en`=1.
- Output register, loaded only when `en`=1:
  - `lcd_de` <= delayed vis
  - `lcd_hsd` <= delayed hs_n
  - `lcd_vsd` <= delayed vs_n
  - `lcd_r/g/b` <= delayed vis ? `red/green/blue` : 0
- Colour is forced to 0 outside the visible region, whatever the renderer drives.
- `frame_start` = en && x_cnt==0 && y_cnt==0, registered so it aligns with the issued coordinate.
- Reset values:
  - x_cnt = 0, y_cnt = 0
  - every delay stage = {vis 0, hs_n 1, vs_n 1}
  - lcd_de = 0, lcd_hsd = 1, lcd_vsd = 1, lcd_r/g/b = 0, frame_start = 0

## Timing
- `x_cnt`/`y_cnt` are registered outputs that change on `clk` rising edges.
- Panel outputs lag the issued coordinate by exactly PIPE_LAT+1 clocks: PIPE_LAT for the renderer, plus 1 for the output register.
- `en` low: all state freezes, including counters, delay line and outputs. Resuming continues seamlessly.
- Reset asserted mid-frame: everything returns to reset values immediately, with no partial-line flush. After release, scanning restarts at (0,0) on the first enabled edge.
- Simultaneous x wrap and y wrap (1055, 524): the next coordinate is (0,0) and `frame_start` pulses for it.
- Out-of-range PIPE_LAT is a compile-time error via an elaboration assertion.

## Configuration
- `MTL_TEST_PATTERN_EN` defined: `red`/`green`/`blue` are ignored. The visible area shows 8 vertical colour bars, each 100 pixels wide, selected by the delayed x coordinate bits [9:0]/100. Bar 0 is white (FF,FF,FF), bar 7 is black, and bars 1-6 are yellow, cyan, green, magenta, red, blue at 0xFF levels. The delay line additionally carries the 11-bit x coordinate.
- Macro undefined: renderer colour passes through as described in Operation, and no x delay stages exist.

## Structure
- Package `mtl_timing_pkg` holds:
  - default timing constants and derived H_TOTAL/V_TOTAL
  - typedef `rgb_t` (three 8-bit fields)
  - typedef `sync_bus_t` {vis, hs_n, vs_n}
  - the colour-bar table
- One sub-module, `mtl_sync_delay`: a parameterised-depth, enable-gated shift register of `sync_bus_t` with reset values as above.

## Test plan
- Reset release, `en`=1, renderer driving a constant 0x56/0xA9/0x98 -> on cycle 3 after release (PIPE_LAT=2) `lcd_de`=1 and lcd_r/g/b = 56/A9/98. After 800 DE-high clocks, DE falls, with r/g/b = 0.
- Count one line -> hsd low exactly 1 clock, 1010 clocks after the first DE-high of the line. Line period is 1056 clocks.
- Count one frame -> vsd low for exactly 1056 clocks, starting 502 lines after the first DE line. `frame_start` pulses every 554400 clocks.
- Toggle `en` low for 37 clocks mid-line -> all outputs hold steady. The line completes with exactly 800 DE-high clocks in total.
- Assert `reset` at x_cnt=400, y_cnt=300 -> outputs go to reset values asynchronously. After release, x_cnt/y_cnt restart at 0,0.
- With `MTL_TEST_PATTERN_EN`, line 0 -> pixels 0-99 are FFFFFF, pixel 100 is FFFF00, and pixels 700-799 are 000000.
